mips_regfile_sb: RTL

Parametrised multi-port register file with an integrated pending-write scoreboard for the pipelined MIPS datapath. It replaces the single-write, two-read register file and sits between decode (reads, issue marking) and writeback (ALU and load-return writes). It adds a configurable number of read ports, a second write port, a hardwired zero register, optional write-to-read bypass, and per-register busy tracking for hazard stalls.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 87 ++++++++
 rtl/mips_regfile_sb.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS register file with scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // Register that is hardwired to zero when ZERO_REG is enabled
    localparam reg_addr_t ZERO_ADDR = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bitmap, set/clear priority, pending counter
// and WAW issue gating. The counter always tracks the popcount of the bitmap.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we0,
    input  logic [ADDR_W-1:0]      waddr0,
    input  logic                   we1,
    input  logic [ADDR_W-1:0]      waddr1,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic                   iss_ready,
    output logic [ADDR_W:0]        busy_cnt,
    output logic [(1<<ADDR_W)-1:0] busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] set_vec_s, clr_vec_s, drop_vec_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             iss_zero_s;

    // Number of set bits in a bitmap (at most two clears land per cycle)
    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Issue gating and next-state bitmap: a same-cycle set beats any clear
    always_comb begin
        set_vec_s  = '0;
        clr_vec_s  = '0;
        iss_zero_s = ZERO_EN && (iss_addr == ZERO_A);
        if (iss_zero_s) begin
            iss_ready = 1'b1;
        end else begin
            iss_ready = ~busy_q[iss_addr];
        end
        if (iss_valid && iss_ready && !iss_zero_s) begin
            set_vec_s[iss_addr] = 1'b1;
        end else begin
            set_vec_s = '0;
        end
        if (we0) begin
            clr_vec_s[waddr0] = 1'b1;
        end else begin
            clr_vec_s[waddr0] = clr_vec_s[waddr0];
        end
        if (we1) begin
            clr_vec_s[waddr1] = 1'b1;
        end else begin
            clr_vec_s[waddr1] = clr_vec_s[waddr1];
        end
        // Only clears that actually drop a busy bit move the counter
        drop_vec_s = busy_q & clr_vec_s & ~set_vec_s;
        busy_d     = (busy_q & ~clr_vec_s) | set_vec_s;
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, |set_vec_s} - popcount(drop_vec_s);
    end

    // Bitmap and counter state, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;
    assign busy_vec = busy_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// Multi-read, dual-write MIPS register file with pending-write scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass).
module mips_regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_vec_s;
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;
    logic              rb_s;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .we0       (we0),
        .waddr0    (waddr0),
        .we1       (we1),
        .waddr1    (waddr1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt),
        .busy_vec  (busy_vec_s)
    );

    // Storage array; port 1 is written last so it wins on an address clash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we0 && !(ZERO_EN && waddr0 == ZERO_A)) begin
                mem_q[waddr0] <= wdata0;
            end
            if (we1 && !(ZERO_EN && waddr1 == ZERO_A)) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    // Read muxing per port: array, optional same-cycle bypass, zero register
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra_s  = '0;
        rd_s  = '0;
        rb_s  = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra_s = raddr[k*ADDR_W +: ADDR_W];
            rd_s = mem_q[ra_s];
            rb_s = busy_vec_s[ra_s];
`ifdef REGFILE_BYPASS_EN
            if (we1 && waddr1 == ra_s) begin
                rd_s = wdata1;
                rb_s = 1'b0;
            end else if (we0 && waddr0 == ra_s) begin
                rd_s = wdata0;
                rb_s = 1'b0;
            end else begin
                rd_s = rd_s;
            end
`endif
            if (ZERO_EN && ra_s == ZERO_A) begin
                rd_s = '0;
                rb_s = 1'b0;
            end else begin
                rd_s = rd_s;
            end
            rdata[k*DATA_W +: DATA_W] = rd_s;
            rbusy[k] = rb_s;
        end
    end

endmodule
